// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for the shared
// combinational ALU.
//
// An operation from requester 0 or 1 is accepted in IDLE. A legal opcode
// drives the ALU inputs from registers for SETTLE cycles (ISSUE). The ALU
// results are then captured and returned on the response channel (RESP),
// tagged with the requester id. Opcode 7 is illegal: the ALU is not driven,
// and an error response goes out on the next cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds op/a/b stable while valid is high and ready is
// low. The response fields stay stable while rsp_valid is high and rsp_ready
// is low.
//
// Parameters:
//   SETTLE        cycles the ALU inputs are held before capture (1..15)
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/ready       request handshake (ready is combinational)
//   req{0,1}_op/a/b            opcode (3b), operands (5b)
//   rsp_valid/ready            response handshake
//   rsp_id/err/data/equality/balance   response fields
//   alu_in1/in2/control/mood   registered ALU inputs
//   alu_out/equality/balance   ALU results
module alu_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [4:0]  req0_a,
    input  logic [4:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [4:0]  req1_a,
    input  logic [4:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic        rsp_equality,
    output logic        rsp_balance,
    output logic [4:0]  alu_in1,
    output logic [4:0]  alu_in2,
    output logic [5:0]  alu_control,
    output logic        alu_mood,
    input  logic [31:0] alu_out,
    input  logic        alu_equality,
    input  logic        alu_balance
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ptr;
    logic [3:0]  cnt;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        sel_id;
    logic [2:0]  sel_op;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic [5:0]  ctrl_dec;
    logic        mood_dec;
    logic        illegal;

    // Fields of the requester that wins this cycle.
    assign sel_id = grant1;
    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    assign illegal  = (sel_op == 3'd7);
    assign ctrl_dec = (sel_op <= 3'd5) ? (6'b000001 << sel_op) : 6'b000000;
    assign mood_dec = (sel_op == 3'd6);

    // The readies are masked by reset so that no accept is seen while reset
    // is held.
    assign req0_ready = grant0 & ~reset;
    assign req1_ready = grant1 & ~reset;
    assign accept     = (grant0 | grant1) & ~reset;

    // Next state and grant. ptr names the preferred requester. A lone valid
    // requester wins whatever ptr says.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid & (~req1_valid | ~ptr);
                grant1 = req1_valid & (~req0_valid | ptr);
                if (grant0 | grant1) begin
                    state_next = illegal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: ALU input registers, settle counter, pointer, response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= 1'b0;
            cnt          <= 4'd0;
            alu_in1      <= 5'd0;
            alu_in2      <= 5'd0;
            alu_control  <= 6'd0;
            alu_mood     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_equality <= 1'b0;
            rsp_balance  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr    <= ~sel_id;
                        rsp_id <= sel_id;
                        if (illegal) begin
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_data     <= 32'd0;
                            rsp_equality <= 1'b0;
                            rsp_balance  <= 1'b0;
                        end else begin
                            alu_in1     <= sel_a;
                            alu_in2     <= sel_b;
                            alu_control <= ctrl_dec;
                            alu_mood    <= mood_dec;
                            // Counts down to 0 in the last ISSUE cycle.
                            cnt         <= 4'(SETTLE - 1);
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd0) begin
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b0;
                        rsp_data     <= alu_out;
                        rsp_equality <= alu_equality;
                        rsp_balance  <= alu_balance;
                        alu_in1      <= 5'd0;
                        alu_in2      <= 5'd0;
                        alu_control  <= 6'd0;
                        alu_mood     <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Three instances (SETTLE = 1, 3, 4) each drive their
// own ALU stub: out = {16'hA5A5, 0, mood, control, in1[3:0], in2[3:0]},
// equality = (in1 == in2), balance = mood.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid [3];
    logic        req0_ready [3];
    logic [2:0]  req0_op    [3];
    logic [4:0]  req0_a     [3];
    logic [4:0]  req0_b     [3];
    logic        req1_valid [3];
    logic        req1_ready [3];
    logic [2:0]  req1_op    [3];
    logic [4:0]  req1_a     [3];
    logic [4:0]  req1_b     [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic        rsp_id     [3];
    logic        rsp_err    [3];
    logic [31:0] rsp_data   [3];
    logic        rsp_equality [3];
    logic        rsp_balance  [3];
    logic [4:0]  alu_in1    [3];
    logic [4:0]  alu_in2    [3];
    logic [5:0]  alu_control [3];
    logic        alu_mood   [3];
    logic [31:0] alu_out    [3];
    logic        alu_equality [3];
    logic        alu_balance  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        assign alu_out[g]      = {16'hA5A5, 1'b0, alu_mood[g], alu_control[g],
                                  alu_in1[g][3:0], alu_in2[g][3:0]};
        assign alu_equality[g] = (alu_in1[g] == alu_in2[g]);
        assign alu_balance[g]  = alu_mood[g];
        alu_arbiter #(.SETTLE(S)) u_dut (
            .clk(clk), .reset(reset),
            .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]),
            .req0_op(req0_op[g]), .req0_a(req0_a[g]), .req0_b(req0_b[g]),
            .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]),
            .req1_op(req1_op[g]), .req1_a(req1_a[g]), .req1_b(req1_b[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_id(rsp_id[g]), .rsp_err(rsp_err[g]), .rsp_data(rsp_data[g]),
            .rsp_equality(rsp_equality[g]), .rsp_balance(rsp_balance[g]),
            .alu_in1(alu_in1[g]), .alu_in2(alu_in2[g]),
            .alu_control(alu_control[g]), .alu_mood(alu_mood[g]),
            .alu_out(alu_out[g]), .alu_equality(alu_equality[g]),
            .alu_balance(alu_balance[g])
        );
    end

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [5:0] ctl_of(input logic [2:0] op);
        logic [5:0] one;
        one = 6'b000001;
        return (op <= 3'd5) ? (one << op) : 6'd0;
    endfunction

    // Expected rsp_data for a legal op, from the stub formula.
    function automatic logic [31:0] exp_data(input logic [2:0] op, input logic [4:0] a,
                                             input logic [4:0] b);
        return {16'hA5A5, 1'b0, (op == 3'd6), ctl_of(op), a[3:0], b[3:0]};
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            req0_valid[k] = 1'b0; req0_op[k] = 3'd0; req0_a[k] = 5'd0; req0_b[k] = 5'd0;
            req1_valid[k] = 1'b0; req1_op[k] = 3'd0; req1_a[k] = 5'd0; req1_b[k] = 5'd0;
            rsp_ready[k]  = 1'b0;
        end
    endtask

    // Starts and ends at posedge + 1.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        reset = 1'b1;
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            req0_valid[k] = 1'b1; req1_valid[k] = 1'b1; req1_op[k] = 3'd2;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({req0_ready[k], req1_ready[k]} !== 2'b00) begin
                bad++; $display("FAIL reset_ready[%0d] got=%b exp=00", k, {req0_ready[k], req1_ready[k]});
            end
            outs = {rsp_valid[k], rsp_id[k], rsp_err[k], rsp_equality[k], rsp_balance[k], rsp_data[k],
                    alu_in1[k], alu_in2[k], alu_control[k], alu_mood[k]};
            total++;
            if (outs !== 54'd0) begin
                bad++; $display("FAIL reset_outputs[%0d] got=%h exp=0", k, outs);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready[0] = 1'b1;
        req0_valid[0] = 1'b1; req0_op[0] = 3'd1; req0_a[0] = 5'd2; req0_b[0] = 5'd4;
        @(negedge clk);
        total++;
        if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
            bad++; $display("FAIL single_accept got=%b exp=10", {req0_ready[0], req1_ready[0]});
        end
        @(posedge clk); #1 req0_valid[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({alu_control[0], alu_in1[0], alu_in2[0], rsp_valid[0]} !== {6'b000010, 5'd2, 5'd4, 1'b0}) begin
            bad++; $display("FAIL single_issue got=%h exp=%h",
                {alu_control[0], alu_in1[0], alu_in2[0], rsp_valid[0]}, {6'b000010, 5'd2, 5'd4, 1'b0});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({rsp_valid[0], rsp_id[0], rsp_err[0], rsp_equality[0], rsp_data[0]} !== {4'b1000, 32'hA5A5_0224}) begin
            bad++; $display("FAIL single_rsp got=%h exp=%h",
                {rsp_valid[0], rsp_id[0], rsp_err[0], rsp_equality[0], rsp_data[0]}, {4'b1000, 32'hA5A5_0224});
        end
        total++;
        if ({alu_control[0], alu_in1[0], alu_in2[0]} !== 16'd0) begin
            bad++; $display("FAIL single_alu_clear got=%h exp=0", {alu_control[0], alu_in1[0], alu_in2[0]});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rsp_valid[0] !== 1'b0) begin
            bad++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic got;
        logic id;
        do_reset();
        rsp_ready[0] = 1'b1;
        req0_valid[0] = 1'b1; req0_op[0] = 3'd0; req0_a[0] = 5'd7;  req0_b[0] = 5'd3;
        req1_valid[0] = 1'b1; req1_op[0] = 3'd5; req1_a[0] = 5'd12; req1_b[0] = 5'd12;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            id  = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (req0_ready[0] || req1_ready[0]) begin
                    got = 1'b1;
                    id  = req1_ready[0];
                    total++;
                    if ({req0_ready[0], req1_ready[0]} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                        bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i,
                            {req0_ready[0], req1_ready[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
                    end
                    total++;
                    if (alu_control[0] !== 6'd0) begin
                        bad++; $display("FAIL b2b_idle_ctl[%0d] got=%b exp=0", i, alu_control[0]);
                    end
                end
                @(posedge clk); #1;
            end
            total++;
            if (!got) begin
                bad++; $display("FAIL b2b_timeout[%0d] got=no_grant exp=grant", i);
            end
            @(negedge clk);
            total++;
            if (alu_control[0] !== (id ? 6'b100000 : 6'b000001)) begin
                bad++; $display("FAIL b2b_ctl[%0d] got=%b exp=%b", i, alu_control[0], id ? 6'b100000 : 6'b000001);
            end
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if ({rsp_valid[0], rsp_id[0], rsp_data[0]} !==
                {1'b1, id, id ? exp_data(3'd5, 5'd12, 5'd12) : exp_data(3'd0, 5'd7, 5'd3)}) begin
                bad++; $display("FAIL b2b_rsp[%0d] got=%h id=%b", i, rsp_data[0], rsp_id[0]);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_mood();
        do_reset();
        rsp_ready[1] = 1'b1;
        req1_valid[1] = 1'b1; req1_op[1] = 3'd6; req1_a[1] = 5'd3; req1_b[1] = 5'd3;
        @(negedge clk);
        total++;
        if ({req0_ready[1], req1_ready[1]} !== 2'b01) begin
            bad++; $display("FAIL mood_accept got=%b exp=01", {req0_ready[1], req1_ready[1]});
        end
        @(posedge clk); #1 req1_valid[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if ({alu_mood[1], alu_control[1], alu_in1[1], alu_in2[1], rsp_valid[1]} !==
                {1'b1, 6'd0, 5'd3, 5'd3, 1'b0}) begin
                bad++; $display("FAIL mood_issue[%0d] got=%h exp=%h", c,
                    {alu_mood[1], alu_control[1], alu_in1[1], alu_in2[1], rsp_valid[1]}, {1'b1, 6'd0, 5'd3, 5'd3, 1'b0});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if ({rsp_valid[1], rsp_id[1], rsp_balance[1], rsp_equality[1], rsp_err[1], rsp_data[1], alu_mood[1]} !==
            {5'b11110, exp_data(3'd6, 5'd3, 5'd3), 1'b0}) begin
            bad++; $display("FAIL mood_rsp got=%h data=%h", {rsp_valid[1], rsp_id[1], rsp_balance[1],
                rsp_equality[1], rsp_err[1], alu_mood[1]}, rsp_data[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        do_reset();
        rsp_ready[0] = 1'b1;
        req0_valid[0] = 1'b1; req0_op[0] = 3'd7; req0_a[0] = 5'd9; req0_b[0] = 5'd9;
        @(negedge clk);
        total++;
        if (req0_ready[0] !== 1'b1) begin
            bad++; $display("FAIL illegal_accept got=%b exp=1", req0_ready[0]);
        end
        @(posedge clk); #1 req0_valid[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({rsp_valid[0], rsp_id[0], rsp_err[0], rsp_equality[0], rsp_balance[0], rsp_data[0]} !==
            {5'b10100, 32'd0}) begin
            bad++; $display("FAIL illegal_rsp got=%h exp=%h",
                {rsp_valid[0], rsp_id[0], rsp_err[0], rsp_equality[0], rsp_balance[0], rsp_data[0]}, {5'b10100, 32'd0});
        end
        total++;
        if ({alu_in1[0], alu_in2[0], alu_control[0], alu_mood[0]} !== 17'd0) begin
            bad++; $display("FAIL illegal_alu got=%h exp=0", {alu_in1[0], alu_in2[0], alu_control[0], alu_mood[0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [35:0] want;
        do_reset();
        req0_valid[1] = 1'b1; req0_op[1] = 3'd2; req0_a[1] = 5'd5; req0_b[1] = 5'd6;
        @(negedge clk);
        total++;
        if (req0_ready[1] !== 1'b1) begin
            bad++; $display("FAIL bp_accept got=%b exp=1", req0_ready[1]);
        end
        @(posedge clk); #1;
        req0_valid[1] = 1'b0;
        req1_valid[1] = 1'b1; req1_op[1] = 3'd3; req1_a[1] = 5'd7; req1_b[1] = 5'd1;
        repeat (3) @(posedge clk);
        #1;
        want = {1'b1, 1'b0, 1'b0, 1'b0, exp_data(3'd2, 5'd5, 5'd6)};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid[1], rsp_id[1], rsp_err[1], rsp_equality[1], rsp_data[1]} !== want ||
                req1_ready[1] !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got=%h rdy1=%b exp=%h rdy1=0", c,
                    {rsp_valid[1], rsp_id[1], rsp_err[1], rsp_equality[1], rsp_data[1]}, req1_ready[1], want);
            end
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        total++;
        if ({rsp_valid[1], req1_ready[1]} !== 2'b10) begin
            bad++; $display("FAIL bp_handshake got=%b exp=10", {rsp_valid[1], req1_ready[1]});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({rsp_valid[1], req1_ready[1]} !== 2'b01) begin
            bad++; $display("FAIL bp_next_grant got=%b exp=01", {rsp_valid[1], req1_ready[1]});
        end
        @(posedge clk); #1 req1_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({rsp_valid[1], rsp_id[1], rsp_data[1]} !== {2'b11, exp_data(3'd3, 5'd7, 5'd1)}) begin
            bad++; $display("FAIL bp_second_rsp got=%b%b %h", rsp_valid[1], rsp_id[1], rsp_data[1]);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [53:0] outs;
        do_reset();
        rsp_ready[2] = 1'b1;
        req0_valid[2] = 1'b1; req0_op[2] = 3'd4; req0_a[2] = 5'd5; req0_b[2] = 5'd6;
        @(negedge clk);
        total++;
        if (req0_ready[2] !== 1'b1) begin
            bad++; $display("FAIL mid_accept got=%b exp=1", req0_ready[2]);
        end
        @(posedge clk); #1 req0_valid[2] = 1'b0;
        @(negedge clk);
        total++;
        if (alu_control[2] !== 6'b010000) begin
            bad++; $display("FAIL mid_issue got=%b exp=010000", alu_control[2]);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid[2] = 1'b1; req0_op[2] = 3'd2; req0_a[2] = 5'd1; req0_b[2] = 5'd1;
        req1_valid[2] = 1'b1; req1_op[2] = 3'd3; req1_a[2] = 5'd2; req1_b[2] = 5'd2;
        @(negedge clk);
        total++;
        if ({req0_ready[2], req1_ready[2]} !== 2'b00) begin
            bad++; $display("FAIL mid_reset_ready got=%b exp=00", {req0_ready[2], req1_ready[2]});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        outs = {rsp_valid[2], rsp_id[2], rsp_err[2], rsp_equality[2], rsp_balance[2], rsp_data[2],
                alu_in1[2], alu_in2[2], alu_control[2], alu_mood[2]};
        total++;
        if (outs !== 54'd0) begin
            bad++; $display("FAIL mid_outputs got=%h exp=0", outs);
        end
        total++;
        if ({req0_ready[2], req1_ready[2]} !== 2'b10) begin
            bad++; $display("FAIL mid_regrant got=%b exp=10", {req0_ready[2], req1_ready[2]});
        end
        @(posedge clk); #1;
        req0_valid[2] = 1'b0; req1_valid[2] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid[2] !== (c == 5)) begin
                bad++; $display("FAIL mid_rsp_timing[%0d] got=%b exp=%b", c, rsp_valid[2], c == 5);
            end
            if (c == 5) begin
                total++;
                if ({rsp_id[2], rsp_data[2]} !== {1'b0, exp_data(3'd2, 5'd1, 5'd1)}) begin
                    bad++; $display("FAIL mid_rsp_data got=%b %h", rsp_id[2], rsp_data[2]);
                end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    // Random traffic checked against a transaction-level model: a grant only
    // when not busy, response after SETTLE+1 cycles (1 for op 7), ALU inputs
    // live only in cycles 1..SETTLE after the accept.
    task automatic test_random(input int k);
        logic [35:0] exp_q[$];
        logic        busy, ptr, held0, held1, e0, e1, erv, id, cur_err, issuing;
        logic [2:0]  op;
        logic [4:0]  a, b;
        logic [16:0] cur_alu, exp_alu;
        int          age, lat, settle;
        settle = settle_of(k);
        do_reset();
        busy = 0; ptr = 0; held0 = 0; held1 = 0; age = 0; lat = 1; cur_err = 0; cur_alu = '0;
        for (int cyc = 0; cyc < 250; cyc++) begin
            if (!held0) begin
                req0_valid[k] = 1'($urandom_range(0, 1));
                req0_op[k] = 3'($urandom_range(0, 7));
                req0_a[k] = 5'($urandom_range(0, 31)); req0_b[k] = 5'($urandom_range(0, 31));
            end
            if (!held1) begin
                req1_valid[k] = 1'($urandom_range(0, 1));
                req1_op[k] = 3'($urandom_range(0, 7));
                req1_a[k] = 5'($urandom_range(0, 31)); req1_b[k] = 5'($urandom_range(0, 31));
            end
            rsp_ready[k] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e0 = !busy && req0_valid[k] && (!req1_valid[k] || ptr == 1'b0);
            e1 = !busy && req1_valid[k] && (!req0_valid[k] || ptr == 1'b1);
            erv = busy && (age >= lat);
            issuing = busy && !cur_err && age >= 1 && age <= settle;
            exp_alu = issuing ? cur_alu : 17'd0;
            total++;
            if ({req0_ready[k], req1_ready[k]} !== {e0, e1}) begin
                bad++; $display("FAIL rnd%0d_ready cyc=%0d got=%b exp=%b", k, cyc, {req0_ready[k], req1_ready[k]}, {e0, e1});
            end
            total++;
            if (rsp_valid[k] !== erv) begin
                bad++; $display("FAIL rnd%0d_rsp_valid cyc=%0d got=%b exp=%b", k, cyc, rsp_valid[k], erv);
            end
            if (erv) begin
                total++;
                if ({rsp_id[k], rsp_err[k], rsp_equality[k], rsp_balance[k], rsp_data[k]} !== exp_q[0]) begin
                    bad++; $display("FAIL rnd%0d_rsp cyc=%0d got=%h exp=%h", k, cyc,
                        {rsp_id[k], rsp_err[k], rsp_equality[k], rsp_balance[k], rsp_data[k]}, exp_q[0]);
                end
            end
            total++;
            if ({alu_in1[k], alu_in2[k], alu_control[k], alu_mood[k]} !== exp_alu) begin
                bad++; $display("FAIL rnd%0d_alu cyc=%0d got=%h exp=%h", k, cyc,
                    {alu_in1[k], alu_in2[k], alu_control[k], alu_mood[k]}, exp_alu);
            end
            @(posedge clk);
            if (busy) begin
                if (erv && rsp_ready[k]) begin
                    busy = 0;
                    void'(exp_q.pop_front());
                end else begin
                    age++;
                end
            end else if (e0 || e1) begin
                id = e1;
                op = id ? req1_op[k] : req0_op[k];
                a  = id ? req1_a[k]  : req0_a[k];
                b  = id ? req1_b[k]  : req0_b[k];
                cur_err = (op == 3'd7);
                cur_alu = {a, b, ctl_of(op), op == 3'd6};
                lat = cur_err ? 1 : settle + 1;
                exp_q.push_back(cur_err ? {id, 3'b100, 32'd0}
                                        : {id, 1'b0, a == b, op == 3'd6, exp_data(op, a, b)});
                busy = 1; age = 1; ptr = ~id;
            end
            held0 = req0_valid[k] && !e0;
            held1 = req1_valid[k] && !e1;
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_mood();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            test_random(k);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared ALU. It accepts encoded operation requests over valid/ready, drives the ALU operand, `control` and `mood` inputs from registers, and holds them for a fixed settle time. It then captures `out`, `equality` and `balance` and returns them on a single response channel tagged with the requester id. It sits between the two issuing units and the single combinational ALU instance.

## Interface
- `SETTLE`, default 1: cycles the ALU inputs are held stable before capture; legal range 1–15.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_op`  in  3  requester 0 opcode
- `req0_a`  in  5  requester 0 operand A
- `req0_b`  in  5  requester 0 operand B
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued this response
- `rsp_err`  out  1  illegal opcode
- `rsp_data`  out  32  captured ALU `out`
- `rsp_equality`  out  1  captured ALU `equality`
- `rsp_balance`  out  1  captured ALU `balance`
- `alu_in1`  out  5  to ALU `in1`
- `alu_in2`  out  5  to ALU `in2`
- `alu_control`  out  6  to ALU `control`, one-hot or zero
- `alu_mood`  out  1  to ALU `mood`
- `alu_out`  in  32  from ALU `out`
- `alu_equality`  in  1  from ALU
- `alu_balance`  in  1  from ALU

## Operation
**Opcode decode**
- op 0–5: `alu_control` = 1 << op, `alu_mood` = 0.
- op 6: `alu_control` = 0, `alu_mood` = 1.
- op 7: illegal. The ALU is not driven.

**States**
- IDLE: `alu_control` = 0, `alu_mood` = 0, operands 0.
  - Arbiter selects one valid requester and asserts only that requester's ready. Ready is combinational from the valids and the priority pointer, and only in IDLE.
  - Legal op → ISSUE. op 7 → RESP with `rsp_err` = 1.
- ISSUE: registered ALU inputs held for exactly `SETTLE` cycles, counted by a 4-bit counter.
  - On the edge ending the last ISSUE cycle: capture `alu_out`, `alu_equality`, `alu_balance` into rsp registers, clear the ALU inputs to zero, go to RESP.
- RESP: `rsp_valid` = 1, all rsp fields stable.
  - On `rsp_valid & rsp_ready`: → IDLE. No new grant in the same cycle.

**Arbitration**
- Round-robin pointer names the preferred requester. Reset value: requester 0.
- On each accept, the pointer moves to the other requester.
- If only one requester is valid, it wins regardless of the pointer.
- At most one ready per cycle. Ready is never asserted outside IDLE.

**Error response**
- `rsp_data` = 0, `rsp_equality` = 0, `rsp_balance` = 0, `rsp_err` = 1, `rsp_id` = requester.

**Reset**
- All outputs go to 0, state goes to IDLE, pointer goes to requester 0.
- Reset mid-ISSUE or mid-RESP drops the operation. No response is produced and the ALU inputs go to 0 the next cycle.
- Requester inputs are ignored while `reset` is high; both readies are 0.

## Timing
**Legal op accepted at cycle T**
- ALU inputs valid from T+1 through T+`SETTLE`.
- Capture at the end of T+`SETTLE`.
- `rsp_valid` from T+`SETTLE`+1.

**Illegal op accepted at T**
- `rsp_valid` at T+1. The ALU inputs stay 0.

**Throughput**
- If the response is taken in its first cycle, the next accept is possible at T+`SETTLE`+2.
- Back-pressure on `rsp_ready` stalls indefinitely, with no data change.

**General**
- All outputs are registered except `req0_ready` and `req1_ready`.
- Requesters must hold op/a/b stable while valid and not ready. Fields are sampled only on the accept cycle.

## Test plan
Benches use an ALU stub: `out` = {16'hA5A5, 1'b0, `mood`, `control`, `in1`[3:0], `in2`[3:0]}, `equality` = (`in1` == `in2`), `balance` = `mood`.

1. Reset, then req0 op=1 a=2 b=4, `SETTLE`=1, `rsp_ready`=1 → accept at T; `alu_control`=6'b000010, `alu_in1`=2, `alu_in2`=4 at T+1; `rsp_valid` at T+2, `rsp_id`=0, `rsp_data`=32'hA5A5_0224, `rsp_equality`=0, `rsp_err`=0.
2. Both requesters continuously valid (req0 op=0, req1 op=5), four transactions → grant order 0,1,0,1; `alu_control` alternates 6'b000001 / 6'b100000; `alu_control` is 0 in every IDLE cycle.
3. req1 op=6 a=3 b=3, `SETTLE`=3 → `alu_mood`=1 and `alu_control`=0 held for exactly 3 cycles; `rsp_balance`=1, `rsp_equality`=1, `rsp_valid` at T+4.
4. req0 op=7 → `rsp_valid` at T+1 with `rsp_err`=1, `rsp_data`=0; ALU inputs never leave 0.
5. `rsp_ready`=0 for 10 cycles during RESP, with req1 valid → rsp fields stable, `req1_ready` stays 0; req1 accepted the cycle after the handshake completes.
6. `reset` pulsed in the middle of ISSUE with `SETTLE`=4 → next cycle all outputs 0; no `rsp_valid` ever appears for the dropped op; next grant goes to requester 0.
